// File: rtl/var_delay_line.sv
// Variable delay line: circular buffer with a runtime-loadable tap distance and fill-based validity.
// Optional VAR_DELAY_LINE_OUTREG_EN registers out/out_valid, adding one ce-cycle of latency.
module var_delay_line #(
  parameter int WIDTH       = 8,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = MAX_DELAY,
  localparam int DW         = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             delay_ld,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [DW-1:0]    cur_delay
);

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [WIDTH-1:0] mem_q [MAX_DELAY];
  logic [AW-1:0]    wp_q, wp_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [DW:0]      rd_sum;
  logic [AW-1:0]    rd_addr;
  logic             vld_c;
  logic [WIDTH-1:0] out_c;

  always_comb begin
    wp_d = wp_q;
    if (ce) begin
      if (int'(wp_q) == MAX_DELAY - 1) wp_d = '0;
      else                             wp_d = wp_q + 1'b1;
    end
  end

  // A load restarts validity; the sample written in the load cycle counts as the first one.
  always_comb begin
    fill_d = fill_q;
    dly_d  = dly_q;
    if (delay_ld) begin
      dly_d  = (int'(delay) > MAX_DELAY) ? DW'(MAX_DELAY) : delay;
      fill_d = ce ? DW'(1) : '0;
    end else if (ce && (fill_q < dly_q)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      fill_q <= '0;
      dly_q  <= DW'(RESET_DELAY);
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
      dly_q  <= dly_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ce && !rst) mem_q[wp_q] <= in;
  end

  // (wp - D) mod MAX_DELAY without a divider; D = MAX_DELAY lands on wp (oldest slot).
  always_comb begin
    rd_sum = (DW+1)'(wp_q) + (DW+1)'(MAX_DELAY) - (DW+1)'(dly_q);
    if (rd_sum >= (DW+1)'(MAX_DELAY)) rd_sum = rd_sum - (DW+1)'(MAX_DELAY);
    rd_addr = AW'(rd_sum);
  end

  always_comb begin
    vld_c = (fill_q >= dly_q);
    out_c = '0;
    if (vld_c) out_c = (dly_q == '0) ? in : mem_q[rd_addr];
  end

  assign cur_delay = dly_q;

`ifdef VAR_DELAY_LINE_OUTREG_EN
  logic [WIDTH-1:0] out_q;
  logic             vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (ce) begin
      out_q <= out_c;
      vld_q <= vld_c;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
`else
  assign out       = out_c;
  assign out_valid = vld_c;
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Randomized bench for var_delay_line against a sample-history reference model.
module tb_var_delay_line;

  localparam int WIDTH     = 8;
  localparam int MAX_DELAY = 16;
  localparam int RST_DLY   = MAX_DELAY;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic             clk = 1'b0;
  logic             rst, ce, delay_ld;
  logic [DW-1:0]    delay;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [DW-1:0]    cur_delay;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: most recent accepted sample at index 0.
  int hist[$];
  int n_since;
  int d_act;
  int ro_out;
  int ro_vld;

  var_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RST_DLY)) dut (
    .clk(clk), .rst(rst), .ce(ce), .delay_ld(delay_ld), .delay(delay), .in(in),
    .out(out), .out_valid(out_valid), .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit l, input int dl, input int x);
    int vc, oc;
    rst = r; ce = c; delay_ld = l; delay = DW'(dl); in = WIDTH'(x);
    #4;
    vc = ((d_act == 0) || (n_since >= d_act)) ? 1 : 0;
    oc = 0;
    if (vc == 1) oc = (d_act == 0) ? x : hist[d_act-1];
`ifdef VAR_DELAY_LINE_OUTREG_EN
    check_eq("out", int'(out), ro_out);
    check_eq("out_valid", int'(out_valid), ro_vld);
`else
    check_eq("out", int'(out), oc);
    check_eq("out_valid", int'(out_valid), vc);
`endif
    check_eq("cur_delay", int'(cur_delay), d_act);
    @(posedge clk);
    if (r) begin
      n_since = 0;
      d_act   = RST_DLY;
      ro_out  = 0;
      ro_vld  = 0;
    end else begin
      if (c) begin
        ro_out = oc;
        ro_vld = vc;
        hist.push_front(x);
        if (hist.size() > MAX_DELAY) void'(hist.pop_back());
      end
      if (l) begin
        d_act   = (dl > MAX_DELAY) ? MAX_DELAY : dl;
        n_since = c ? 1 : 0;
      end else if (c && n_since < 1000) begin
        n_since++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; delay_ld = 1'b0; delay = '0; in = '0;
    n_since = 0; d_act = RST_DLY; ro_out = 0; ro_vld = 0;
    repeat (2) @(posedge clk);
    #1;

    // Fill from reset at the default delay
    for (int i = 1; i <= 24; i++) step(0, 1, 0, 0, i);
    // Delay 3 with alternating ce
    step(0, 1, 1, 3, 100);
    for (int i = 0; i < 16; i++) step(0, (i % 2) == 1, 0, 0, 101 + i);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 120 + i);
    // Switch 3 -> 5 while running
    step(0, 1, 1, 5, 130);
    for (int i = 1; i <= 10; i++) step(0, 1, 0, 0, 130 + i);
    // Oversized request clamps to MAX_DELAY; run across wrap
    step(0, 1, 1, 31, 150);
    for (int i = 1; i <= 40; i++) step(0, 1, 0, 0, (150 + i) % 256);
    // Zero delay passthrough
    step(0, 1, 1, 0, 7);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 200 + i);
    // Reset wins over a simultaneous load, then refill
    step(1, 1, 1, 2, 9);
    for (int i = 1; i <= 20; i++) step(0, 1, 0, 0, i);
    // Load with ce low
    step(0, 0, 1, 4, 55);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 60 + i);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/var_delay_line.md
VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter MAX_DELAY, default 16, largest supported delay in ce-enabled cycles (>=1).
REQ-003 Parameter RESET_DELAY, default MAX_DELAY, active delay after reset (0..MAX_DELAY).
REQ-004 Local DW = $clog2(MAX_DELAY+1), the width of the delay value.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 ce  input  1  clock enable; one sample accepted and the line advanced per cycle with ce=1.
REQ-008 delay_ld  input  1  strobe; loads delay into the active delay register.
REQ-009 delay  input  DW  requested delay, sampled only when delay_ld=1.
REQ-010 in  input  WIDTH  input sample.
REQ-011 out  output  WIDTH  delayed sample; all zeros while out_valid=0.
REQ-012 out_valid  output  1  out holds a sample delayed by exactly the active delay.
REQ-013 cur_delay  output  DW  active delay value.

Function
REQ-014 Storage shall be a circular buffer of MAX_DELAY words of WIDTH bits with write pointer wp (0..MAX_DELAY-1); storage is not reset.
REQ-015 On ce=1: mem[wp] <= in; wp increments, wrapping from MAX_DELAY-1 to 0.
REQ-016 For active delay D>=1: out = mem[(wp-D) mod MAX_DELAY] combinationally, i.e. out equals the in value accepted D ce-cycles earlier, matching a chain of D ce-gated registers.
REQ-017 D=MAX_DELAY reads the slot at wp, the oldest sample, before it is overwritten; this is legal.
REQ-018 For D=0: out = in combinationally, and out_valid = 1.
REQ-019 Fill counter fill (0..MAX_DELAY) shall increment on ce=1 and saturate at D.
REQ-020 out_valid = (fill >= D).
REQ-021 out shall be forced to zero whenever out_valid=0.
REQ-022 ce=0 shall freeze wp, fill and memory.
REQ-023 delay_ld=1 acts regardless of ce: cur_delay <= min(delay, MAX_DELAY); fill <= (ce ? 1 : 0).
REQ-024 On delay_ld=1 with ce=1, the write shall occur, and that sample counts as the first sample under the new delay.
REQ-025 Memory contents and wp shall be unaffected by delay_ld.
REQ-026 With delay_ld=1 and rst=1 in the same cycle, rst shall win.

Reset
REQ-027 On rst=1 at a clock edge: wp <= 0, fill <= 0, cur_delay <= RESET_DELAY; ce and delay_ld are ignored that cycle.
REQ-028 After reset, out = 0 and out_valid = 0 (out_valid = 1 and out = in if RESET_DELAY = 0), until RESET_DELAY ce-cycles have elapsed.
REQ-029 Reset mid-operation shall discard all delayed samples logically (validity restarts); memory contents are not cleared.

Configuration
REQ-030 Macro VAR_DELAY_LINE_OUTREG_EN.
REQ-031 Defined: out and out_valid are registered, updating only on ce=1 from the REQ-016..REQ-021 values; total latency is D+1 ce-cycles (1 for D=0); rst clears both to 0.
REQ-032 Not defined: out and out_valid are combinational as specified, with latency D.

Verification
REQ-033 rst; D=16 default; in=1,2,3,... with ce=1 every cycle -> out_valid rises after the 16th ce; out=1 on that cycle, then 2,3,...; out=0 before.
REQ-034 D=3; ce toggled 1,0,1,0,... -> out equals in from 3 ce-cycles earlier; values hold during ce=0 cycles; out_valid after 3rd ce.
REQ-035 Running at D=3 with valid output; delay_ld=1, delay=5, ce=1 -> out_valid=0 and out=0 immediately; out_valid=1 after 5 ce-cycles including the load cycle; out = the sample accepted 5 ce-cycles earlier.
REQ-036 delay_ld with delay=31, MAX_DELAY=16 -> cur_delay=16; out_valid after 16 ce; out correct across wp wrap (run 40 samples).
REQ-037 delay_ld, delay=0 -> out=in same cycle and out_valid=1; with VAR_DELAY_LINE_OUTREG_EN defined, out=in one ce later.
REQ-038 rst asserted mid-stream with delay_ld=1 in the same cycle -> cur_delay=RESET_DELAY, out=0, out_valid=0, and the refill timing matches REQ-033.
